pia_char_fifo: RTL
==================

Name: pia_char_fifo

Overview:
Parametrised successor to the single-register CPU-to-terminal character latch. It accepts characters from an external CPU over the asynchronous DA strobe, synchronises the strobe into the terminal clock domain, and buffers characters in a DEPTH-entry show-ahead FIFO. The video terminal drains the FIFO with a valid/ack handshake. Optional lowercase-to-uppercase folding and a sticky overflow flag are included. It sits between the CPU-facing pins and video_terminal in the top level.

Parameters:
WIDTH, 7, character width in bits; must be >= 7.
DEPTH, 16, FIFO entries; power of 2, >= 2.
SYNC_STAGES, 2, flops in the da synchroniser; >= 2.
UPPER_FOLD, 1, 1 = fold 0x61..0x7A to 0x41..0x5A on write; 0 = pass through unchanged.

Ports:
clk  input  1  terminal clock, all logic on rising edge.
clr  input  1  reset, asynchronous, active-high.
rd  input  WIDTH  character from CPU; must be stable from the da rise until SYNC_STAGES+1 clk edges later.
da  input  1  asynchronous data-available strobe from CPU; the rising edge requests a write.
rda  output  1  ready-for-data to CPU; high when FIFO not full.
dout  output  WIDTH  head-of-FIFO character, show-ahead.
dout_valid  output  1  FIFO not empty.
dout_ack  input  1  terminal consumed dout this cycle; pops when dout_valid=1.
count  output  $clog2(DEPTH)+1  current occupancy.
overflow  output  1  sticky; set when a write arrives while full.
clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (clr=1, async): synchroniser flops and edge-history flop = 0; read/write pointers = 0; count = 0; overflow = 0; rda = 1; dout_valid = 0; dout = mem[0] (contents undefined, don't-care while dout_valid = 0).
- Synchroniser: da passes through SYNC_STAGES flops (s[0..N-1]), then a history flop h. push_req = s[N-1] & ~h, a one-cycle pulse per da rising edge. Holding da high produces exactly one push.
- Capture: on a cycle with push_req, rd is sampled at that clock edge. With UPPER_FOLD=1 and rd[6:0] in 0x61..0x7A, 0x20 is subtracted from bits [6:0]; any bits above 6 pass unchanged.
- Latency: for the first clk edge that samples da=1 as edge 0, the write occurs at edge SYNC_STAGES. dout_valid is high after that edge (SYNC_STAGES+1 cycles of latency into an empty FIFO).
- Pop: dout_ack & dout_valid advances the read pointer at the clock edge. dout_ack while empty is ignored and has no side effects.
- Full: push_req while count==DEPTH and no pop in the same cycle drops the character, sets overflow, and leaves pointers and count unchanged.
- Simultaneous push and pop:
  - When full: both are accepted and count is unchanged.
  - When empty: the push is accepted and the ack is ignored; count becomes 1.
  - Otherwise: both are accepted and count is unchanged.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH.
- rda = (count != DEPTH), registered from next-state so it is glitch-free. It falls in the same cycle count reaches DEPTH and rises in the cycle after the pop that frees a slot.
- overflow: set has priority over clr_ovf when both occur in the same cycle. It clears only via clr_ovf or clr.
- clr mid-operation: all state clears immediately. A da pulse already in the synchroniser is discarded. A da held high across the release of clr produces one push once synchronised, because h=0 after reset.

Decomposition:
- Package pia_pkg holds:
  - ASCII_LC_A = 7'h61, ASCII_LC_Z = 7'h7A, CASE_OFFSET = 7'h20.
  - Function fold_upper(WIDTH-bit value).
  - Localparam helper for pointer width.
- Sub-module sync_edge_det (parameter STAGES) holds the synchroniser plus rising-edge pulse. It is reused for any future asynchronous strobe such as the keyboard strobe.
- FIFO storage and pointer logic stay in pia_char_fifo.

Test Plan:
- Reset then single char: pulse da with rd=0x41 -> dout_valid rises exactly 3 clk edges after da is first sampled (SYNC_STAGES=2); dout=0x41, count=1. After a dout_ack pulse -> dout_valid=0, count=0.
- Case fold: write 0x61, 0x7A, 0x7B, 0x60 with UPPER_FOLD=1 -> read back 0x41, 0x5A, 0x7B, 0x60. With UPPER_FOLD=0 -> read back unchanged.
- Fill and overflow: 16 writes of 0x30..0x3F without ack -> rda=0 and count=16 after the 16th. A 17th write (0x40) -> overflow=1 and the character is dropped. Draining 16 reads returns 0x30..0x3F in order. clr_ovf -> overflow=0.
- Full with simultaneous push and pop: at count=16, align a push of 0x55 with dout_ack -> count stays 16, overflow stays 0, and 0x55 is read last.
- Long da high: hold da=1 for 50 cycles -> exactly one push, count=1. Ack on empty FIFO -> no change.
- Reset mid-operation: assert clr with count=5 and a da pulse in flight -> count=0, dout_valid=0, rda=1, overflow=0. No write from the in-flight pulse appears after clr releases.

Source files
------------

// File: rtl/pia_pkg.sv
// pia_pkg: shared character constants, case-fold helper and pointer-width helper for the PIA character path
package pia_pkg;
  localparam logic [6:0] ASCII_LC_A  = 7'h61;
  localparam logic [6:0] ASCII_LC_Z  = 7'h7A;
  localparam logic [6:0] CASE_OFFSET = 7'h20;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic logic [6:0] fold_upper(input logic [6:0] c);
    return (c >= ASCII_LC_A && c <= ASCII_LC_Z) ? c - CASE_OFFSET : c;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: STAGES-flop synchroniser for async_in, emits a one-cycle pulse per rising edge (clk, rst async high, async_in -> pulse)
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);
  logic [STAGES-1:0] s;
  logic h;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s <= '0;
      h <= 1'b0;
    end else begin
      s <= {s[STAGES-2:0], async_in};
      h <= s[STAGES-1];
    end
  assign pulse = s[STAGES-1] & ~h;
endmodule

// File: rtl/pia_char_fifo.sv
// pia_char_fifo: CPU da/rd character capture into a DEPTH-entry show-ahead FIFO drained by dout/dout_valid/dout_ack, with rda, count, sticky overflow/clr_ovf and async reset clr
module pia_char_fifo
  import pia_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit UPPER_FOLD  = 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         rd,
  input  logic                     da,
  output logic                     rda,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt_nxt;
  logic push_req, full, pop, push_ok;
  logic [WIDTH-1:0] wdata;
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(clr),
    .async_in(da),
    .pulse(push_req)
  );
  assign full       = count == FULL_CNT;
  assign dout_valid = count != '0;
  assign pop        = dout_ack & dout_valid;
  // a pop in the same cycle frees the slot a full FIFO needs for the push
  assign push_ok    = push_req & (~full | pop);
  assign cnt_nxt    = count + (AW+1)'(push_ok) - (AW+1)'(pop);
  assign dout       = mem[rp];
  always_comb begin
    wdata      = rd;
    wdata[6:0] = UPPER_FOLD ? fold_upper(rd[6:0]) : rd[6:0];
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= wdata;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      rda      <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wp       <= wp + AW'(push_ok);
      rp       <= rp + AW'(pop);
      count    <= cnt_nxt;
      rda      <= cnt_nxt != FULL_CNT;
      overflow <= (push_req & ~push_ok) | (overflow & ~clr_ovf);
    end
endmodule
